// File: rtl/panel_write_serializer.sv
// Panel write serializer: queues multi-panel write requests in a FIFO and
// replays each one as a sequence of single-panel framebuffer writes, lowest
// panel first.
// Ports:
//   clock, reset                   sole clock, synchronous active-high reset
//   ctrl_en/wr/addr/wdat           write request (ctrl_en != 0 requests a push)
//   fb_valid/fb_ready              framebuffer request handshake
//   fb_panel/wr/addr/wdat          current panel write payload
//   overflow, drop_count           sticky drop flag and saturating drop counter
//   overflow_clr                   clears overflow and drop_count
//   fifo_level                     FIFO occupancy (head stays counted until fully serialized)
module panel_write_serializer #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            ctrl_en,
    input  logic [3:0]            ctrl_wr,
    input  logic [15:0]           ctrl_addr,
    input  logic [23:0]           ctrl_wdat,
    output logic                  fb_valid,
    input  logic                  fb_ready,
    output logic [2:0]            fb_panel,
    output logic [3:0]            fb_wr,
    output logic [15:0]           fb_addr,
    output logic [23:0]           fb_wdat,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [15:0]           drop_count,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [5:0]  en;
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [23:0] wdat;
    } entry_t;

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t                state, state_nxt;
    logic [5:0]            mask, mask_nxt, mask_clr;
    logic [2:0]            panel_nxt;
    logic                  valid_nxt;
    logic                  load, pop, push, drop, full;
    entry_t                ld_entry;
    entry_t                mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr, rptr_inc;

    function automatic logic [2:0] lowest_idx(input logic [5:0] m);
        lowest_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) lowest_idx = 3'(i);
        end
    endfunction

    // Full is judged on the registered level, so a same-edge pop never frees room.
    assign full     = (fifo_level == LW'(DEPTH));
    assign push     = !reset && (ctrl_en != 6'd0) && !full;
    assign drop     = !reset && (ctrl_en != 6'd0) && full;
    assign rptr_inc = rptr + DEPTH_LOG2'(1);
    assign mask_clr = mask & (mask - 6'd1);

    // Drain FSM next-state and output decode.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        valid_nxt = fb_valid;
        load      = 1'b0;
        pop       = 1'b0;
        ld_entry  = mem[rptr];
        case (state)
            IDLE: begin
                if (fifo_level != LW'(0)) begin
                    load      = 1'b1;
                    mask_nxt  = ld_entry.en;
                    valid_nxt = 1'b1;
                    state_nxt = SERIAL;
                end
            end
            SERIAL: begin
                if (fb_ready) begin
                    if (mask_clr == 6'd0) begin
                        pop = 1'b1;
                        // Only entries already written behind the head can be chained.
                        if (fifo_level > LW'(1)) begin
                            load     = 1'b1;
                            ld_entry = mem[rptr_inc];
                            mask_nxt = ld_entry.en;
                        end else begin
                            mask_nxt  = 6'd0;
                            valid_nxt = 1'b0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        mask_nxt = mask_clr;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        panel_nxt = lowest_idx(mask_nxt);
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Output payload, remaining mask and FIFO bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask       <= 6'd0;
            fb_valid   <= 1'b0;
            fb_panel   <= 3'd0;
            fb_wr      <= 4'd0;
            fb_addr    <= 16'd0;
            fb_wdat    <= 24'd0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            mask     <= mask_nxt;
            fb_valid <= valid_nxt;
            fb_panel <= panel_nxt;
            if (load) begin
                fb_wr   <= ld_entry.wr;
                fb_addr <= ld_entry.addr;
                fb_wdat <= ld_entry.wdat;
            end
            if (push) wptr <= wptr + DEPTH_LOG2'(1);
            if (pop)  rptr <= rptr_inc;
            if (push && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (pop && !push) fifo_level <= fifo_level - LW'(1);
        end
    end

    // FIFO storage; no reset needed since reads are gated by fifo_level.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= '{en: ctrl_en, wr: ctrl_wr, addr: ctrl_addr, wdat: ctrl_wdat};
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-edge clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr)                drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else if (overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end
    end

endmodule

// File: tb/tb_panel_write_serializer.sv
// Self-checking bench for panel_write_serializer: directed table, hand-written
// corner sequences and a random stream against a queue-based reference model.
module tb_panel_write_serializer;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [5:0]          ctrl_en = '0;
    logic [3:0]          ctrl_wr = '0;
    logic [15:0]         ctrl_addr = '0;
    logic [23:0]         ctrl_wdat = '0;
    logic                fb_valid;
    logic                fb_ready = 1'b0;
    logic [2:0]          fb_panel;
    logic [3:0]          fb_wr;
    logic [15:0]         fb_addr;
    logic [23:0]         fb_wdat;
    logic                overflow;
    logic                overflow_clr = 1'b0;
    logic [15:0]         drop_count;
    logic [DEPTH_LOG2:0] fifo_level;

    panel_write_serializer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock(clock), .reset(reset),
        .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
        .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_panel(fb_panel),
        .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_wdat(fb_wdat),
        .overflow(overflow), .overflow_clr(overflow_clr),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  en;
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [23:0] wdat;
    } req_t;

    typedef struct {
        logic        rst;
        logic [5:0]  en;
        logic        rdy;
        logic        clr;
        logic [15:0] addr;
        int          exp_level;
        logic        exp_ovf;
        int          exp_cnt;
        logic        exp_valid;
        int          exp_panel;
    } vec_t;

    // Reference model state
    req_t        q[$];
    logic [5:0]  m_rem;
    logic        m_ovf;
    int          m_cnt;
    int          hs_count;

    int vectors;
    int miscompares;

    // Previous-cycle view for the hold/stability rule
    logic        p_valid, p_ready, p_rst;
    logic [46:0] p_pay;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [5:0] m);
        for (int i = 0; i < 6; i++) if (m[i]) return i;
        return -1;
    endfunction

    // One clock edge: update the model from inputs and visible handshake, then check.
    task automatic cycle();
        logic hs, full, popped, dropped;
        int   pn;
        hs      = fb_valid && fb_ready;
        p_valid = fb_valid;
        p_ready = fb_ready;
        p_rst   = reset;
        p_pay   = {fb_panel, fb_wr, fb_addr, fb_wdat};
        popped  = 1'b0;
        dropped = 1'b0;
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
            m_rem = '0;
        end else begin
            full = (q.size() == DEPTH);
            if (hs) begin
                chk("hs_has_entry", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    pn = lowest(m_rem);
                    chk("hs_panel", 64'(fb_panel), 64'(pn));
                    chk("hs_wr",    64'(fb_wr),    64'(q[0].wr));
                    chk("hs_addr",  64'(fb_addr),  64'(q[0].addr));
                    chk("hs_wdat",  64'(fb_wdat),  64'(q[0].wdat));
                    hs_count++;
                    if (pn >= 0) m_rem[pn] = 1'b0;
                    if (m_rem == 6'd0) begin
                        void'(q.pop_front());
                        popped = 1'b1;
                    end
                end
            end
            if (ctrl_en != 6'd0) begin
                if (full) begin
                    dropped = 1'b1;
                    m_ovf   = 1'b1;
                    m_cnt   = overflow_clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
                end else begin
                    if (q.size() == 0) m_rem = ctrl_en;
                    q.push_back('{en: ctrl_en, wr: ctrl_wr, addr: ctrl_addr, wdat: ctrl_wdat});
                end
            end
            if (!dropped && overflow_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
            if (popped && q.size() != 0) m_rem = q[0].en;
        end
        @(posedge clock);
        #1;
        chk("fifo_level", 64'(fifo_level), 64'(q.size()));
        chk("overflow",   64'(overflow),   64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_cnt));
        if (fb_valid) chk("panel_range", 64'(fb_panel <= 3'd5), 64'd1);
        if (p_valid && !p_ready && !p_rst) begin
            chk("valid_held",   64'(fb_valid), 64'd1);
            chk("payload_held", 64'({fb_panel, fb_wr, fb_addr, fb_wdat}), 64'(p_pay));
        end
    endtask

    task automatic set_req(input logic [5:0] en, input logic [15:0] addr);
        ctrl_en   = en;
        ctrl_addr = addr;
        ctrl_wr   = addr[3:0] ^ 4'hA;
        ctrl_wdat = {8'h5A, addr};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int  n;
        logic done;
        fb_ready = 1'b1;
        set_req(6'd0, 16'd0);
        done = 1'b0;
        n    = 0;
        while (!done && n < budget) begin
            cycle();
            n++;
            if (fifo_level == '0 && !fb_valid) done = 1'b1;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    vec_t tbl[12];

    initial begin
        vectors     = 0;
        miscompares = 0;
        hs_count    = 0;
        m_rem = '0; m_ovf = 1'b0; m_cnt = 0;

        tbl[0]  = '{1'b0, 6'h01, 1'b0, 1'b1, 16'h0300, 16, 1'b1, 1, 1'b1, 0};
        tbl[1]  = '{1'b0, 6'h00, 1'b0, 1'b0, 16'h0000, 16, 1'b1, 1, 1'b1, 0};
        tbl[2]  = '{1'b0, 6'h02, 1'b0, 1'b0, 16'h0301, 16, 1'b1, 2, 1'b1, 0};
        tbl[3]  = '{1'b0, 6'h00, 1'b0, 1'b1, 16'h0000, 16, 1'b0, 0, 1'b1, 0};
        tbl[4]  = '{1'b0, 6'h04, 1'b0, 1'b0, 16'h0302, 16, 1'b1, 1, 1'b1, 0};
        tbl[5]  = '{1'b0, 6'h00, 1'b0, 1'b1, 16'h0000, 16, 1'b0, 0, 1'b1, 0};
        tbl[6]  = '{1'b1, 6'h01, 1'b0, 1'b1, 16'h0303,  0, 1'b0, 0, 1'b0, 0};
        tbl[7]  = '{1'b0, 6'h2A, 1'b0, 1'b0, 16'h0304,  1, 1'b0, 0, 1'b0, 0};
        tbl[8]  = '{1'b0, 6'h00, 1'b0, 1'b0, 16'h0000,  1, 1'b0, 0, 1'b1, 1};
        tbl[9]  = '{1'b0, 6'h00, 1'b1, 1'b0, 16'h0000,  1, 1'b0, 0, 1'b1, 3};
        tbl[10] = '{1'b0, 6'h00, 1'b1, 1'b0, 16'h0000,  1, 1'b0, 0, 1'b1, 5};
        tbl[11] = '{1'b0, 6'h00, 1'b1, 1'b0, 16'h0000,  0, 1'b0, 0, 1'b0, 0};

        #1;
        do_reset();
        chk("rst_valid", 64'(fb_valid), 64'd0);
        chk("rst_panel", 64'(fb_panel), 64'd0);
        chk("rst_wr",    64'(fb_wr),    64'd0);
        chk("rst_addr",  64'(fb_addr),  64'd0);
        chk("rst_wdat",  64'(fb_wdat),  64'd0);

        // Single-panel write into empty FIFO: one-cycle load latency, one handshake.
        fb_ready  = 1'b1;
        ctrl_en   = 6'b000001; ctrl_wr = 4'h3; ctrl_addr = 16'h0010; ctrl_wdat = 24'h123456;
        cycle();
        chk("lat_valid_e", 64'(fb_valid), 64'd0);
        set_req(6'd0, 16'd0);
        cycle();
        chk("lat_valid_e1", 64'(fb_valid), 64'd1);
        chk("lat_panel",    64'(fb_panel), 64'd0);
        chk("lat_addr",     64'(fb_addr),  64'h0010);
        chk("lat_wdat",     64'(fb_wdat),  64'h123456);
        hs_count = 0;
        cycle();
        chk("single_hs",   64'(hs_count), 64'd1);
        chk("single_idle", 64'(fb_valid), 64'd0);

        // Fill FIFO with fb_ready low, then table-driven overflow/clear/reset/serialize.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_req(6'h01, 16'(16'h0100 + i));
            cycle();
        end
        for (int i = 0; i < 12; i++) begin
            reset        = tbl[i].rst;
            fb_ready     = tbl[i].rdy;
            overflow_clr = tbl[i].clr;
            set_req(tbl[i].en, tbl[i].addr);
            cycle();
            chk($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_ovf", i),   64'(overflow),   64'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_cnt", i),   64'(drop_count), 64'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_valid", i), 64'(fb_valid),   64'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_panel", i), 64'(fb_panel), 64'(tbl[i].exp_panel));
        end
        reset = 1'b0; overflow_clr = 1'b0;

        // 17 pushes while stalled: one drop, then drain 16 in order.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_req(6'(1 << (i % 6)), 16'(16'h0200 + i));
            cycle();
        end
        set_req(6'd0, 16'd0);
        chk("full_level", 64'(fifo_level), 64'd16);
        chk("full_ovf",   64'(overflow),   64'd1);
        chk("full_cnt",   64'(drop_count), 64'd1);
        for (int i = 0; i < 4; i++) cycle();
        hs_count = 0;
        drain("full_drain_done", 100);
        chk("full_drain_hs", 64'(hs_count), 64'd16);

        // Reset mid-serialization with 5 entries queued.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(6'b110011, 16'(16'h0400 + i));
            cycle();
        end
        set_req(6'd0, 16'd0);
        cycle();
        fb_ready = 1'b1;
        cycle();
        chk("pre_rst_level", 64'(fifo_level), 64'd5);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_valid", 64'(fb_valid),   64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        set_req(6'b000110, 16'h0500);
        cycle();
        hs_count = 0;
        drain("post_rst_drain_done", 20);
        chk("post_rst_hs", 64'(hs_count), 64'd2);

        // Random push stream with random backpressure and occasional clears.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] en;
            en = 6'($urandom_range(1, 63));
            if ($urandom_range(0, 3) == 0) en = 6'd0;
            set_req(en, 16'($urandom));
            ctrl_wdat    = 24'($urandom);
            fb_ready     = 1'($urandom_range(0, 1));
            overflow_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        overflow_clr = 1'b0;
        drain("rand_drain_done", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
